// File: rtl/sdram_chip_responder.sv
// SDR SDRAM device model: command decode, per-bank rows, burst engine,
// CAS-latency read pipeline and sticky protocol-error reporting.
module sdram_chip_responder #(
  parameter int ROW_W = 4,
  parameter int COL_W = 8,
  parameter int TRCD  = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_wire_addr,
  input  logic [1:0]  sdram_wire_ba,
  input  logic        sdram_wire_cs_n,
  input  logic        sdram_wire_ras_n,
  input  logic        sdram_wire_cas_n,
  input  logic        sdram_wire_we_n,
  input  logic        sdram_wire_cke,
  input  logic [1:0]  sdram_wire_dqm,
  inout  wire  [15:0] sdram_wire_dq,
  output logic        mode_valid,
  output logic        err_flag,
  output logic [2:0]  err_code
);
  localparam int AW = 2 + ROW_W + COL_W;
  localparam int CW = $clog2(TRCD + 2);

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} bstate_t;

  logic [3:0] cmd;
  logic       cke;
  logic       a10;
  logic [1:0] ba;
  logic       unused_ok;

  assign cmd = {sdram_wire_cs_n, sdram_wire_ras_n,
                sdram_wire_cas_n, sdram_wire_we_n};
  assign cke = sdram_wire_cke;
  assign a10 = sdram_wire_addr[10];
  assign ba  = sdram_wire_ba;
  assign unused_ok = ^sdram_wire_addr;

  logic is_act, is_rd, is_wr, is_pre;
  logic is_ref, is_bst, is_lmr;

  always_comb begin
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    is_ref = 1'b0;
    is_bst = 1'b0;
    is_lmr = 1'b0;
    if (cke) begin
      unique case (cmd)
        4'b0011: is_act = 1'b1;
        4'b0101: is_rd  = 1'b1;
        4'b0100: is_wr  = 1'b1;
        4'b0010: is_pre = 1'b1;
        4'b0001: is_ref = 1'b1;
        4'b0110: is_bst = 1'b1;
        4'b0000: is_lmr = 1'b1;
        default: ;
      endcase
    end
  end

  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];
  logic [CW-1:0]    bank_cnt [4];
  logic [1:0]       bl_log;
  logic             cl3;

  bstate_t          bstate, bstate_n;
  logic [1:0]       b_ba;
  logic [ROW_W-1:0] b_row;
  logic [COL_W-1:0] b_col;
  logic [2:0]       b_beat;
  logic             b_ap;

  logic [2:0]  pv;
  logic [15:0] pd [3];
  logic [1:0]  pm1, pm2;
  logic [15:0] mem [2**AW];

  logic       lmr_ok, rw;
  logic [2:0] cmd_err;
  logic       ok_rd, ok_wr, ok_act, ok_lmr;

  assign lmr_ok = !sdram_wire_addr[2] && !sdram_wire_addr[3] &&
                  (sdram_wire_addr[6:4] == 3'd2 ||
                   sdram_wire_addr[6:4] == 3'd3);
  assign rw = is_rd | is_wr;

  always_comb begin
    cmd_err = 3'd0;
    if (rw && !mode_valid)                   cmd_err = 3'd1;
    else if (rw && !bank_open[ba])           cmd_err = 3'd2;
    else if (rw && bank_cnt[ba] < CW'(TRCD)) cmd_err = 3'd3;
    else if (is_act && bank_open[ba])        cmd_err = 3'd4;
    else if (is_ref && |bank_open)           cmd_err = 3'd4;
    else if (is_lmr && !lmr_ok)              cmd_err = 3'd5;
  end

  assign ok_rd  = is_rd  && cmd_err == 3'd0;
  assign ok_wr  = is_wr  && cmd_err == 3'd0;
  assign ok_act = is_act && cmd_err == 3'd0;
  assign ok_lmr = is_lmr && cmd_err == 3'd0;

  logic             start, pre_hit, cont, last;
  logic             beat_rd, beat_wr, ap_close;
  logic [1:0]       beat_ba;
  logic [ROW_W-1:0] beat_row;
  logic [COL_W-1:0] base, blmask, beat_col;
  logic [2:0]       beat_k, blm;
  logic [AW-1:0]    beat_addr;
  logic [15:0]      mem_q;

  // The command cycle carries beat 0; later beats come from the burst regs.
  always_comb begin
    start    = ok_rd | ok_wr;
    pre_hit  = is_pre && bstate != B_IDLE && (a10 || ba == b_ba);
    cont     = cke && bstate != B_IDLE && !start && !pre_hit;
    beat_ba  = start ? ba : b_ba;
    beat_row = start ? bank_row[ba] : b_row;
    base     = start ? sdram_wire_addr[COL_W-1:0] : b_col;
    beat_k   = start ? 3'd0 : b_beat;
    blm      = 3'((4'd1 << bl_log) - 4'd1);
    blmask   = COL_W'(blm);
    beat_col = (base & ~blmask) | ((base + COL_W'(beat_k)) & blmask);
    last     = beat_k == blm;
    beat_rd  = ok_rd | (cont && bstate == B_READ);
    beat_wr  = ok_wr | (cont && bstate == B_WRITE);
    ap_close = (beat_rd | beat_wr) && last && (start ? a10 : b_ap);
  end

  always_comb begin
    bstate_n = bstate;
    if (start)
      bstate_n = last ? B_IDLE : (ok_rd ? B_READ : B_WRITE);
    else if (cke && bstate != B_IDLE && (pre_hit || is_bst || last))
      bstate_n = B_IDLE;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) bstate <= B_IDLE;
    else if (cke)    bstate <= bstate_n;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      b_ba   <= '0;
      b_row  <= '0;
      b_col  <= '0;
      b_beat <= '0;
      b_ap   <= 1'b0;
    end else if (start) begin
      b_ba   <= ba;
      b_row  <= bank_row[ba];
      b_col  <= sdram_wire_addr[COL_W-1:0];
      b_beat <= 3'd1;
      b_ap   <= a10;
    end else if (cont) begin
      b_beat <= b_beat + 3'd1;
    end
  end

  // Counter holds cycles elapsed since ACTIVE, saturating at TRCD.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bank_open <= '0;
      for (int i = 0; i < 4; i++) begin
        bank_row[i] <= '0;
        bank_cnt[i] <= '0;
      end
    end else if (cke) begin
      for (int i = 0; i < 4; i++) begin
        if (bank_cnt[i] < CW'(TRCD))
          bank_cnt[i] <= bank_cnt[i] + CW'(1);
        if ((is_pre && (a10 || ba == 2'(i))) ||
            (ap_close && beat_ba == 2'(i)))
          bank_open[i] <= 1'b0;
        if (ok_act && ba == 2'(i)) begin
          bank_open[i] <= 1'b1;
          bank_row[i]  <= sdram_wire_addr[ROW_W-1:0];
          bank_cnt[i]  <= CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mode_valid <= 1'b0;
      bl_log     <= '0;
      cl3        <= 1'b0;
      err_flag   <= 1'b0;
      err_code   <= '0;
    end else if (cke) begin
      if (ok_lmr) begin
        mode_valid <= 1'b1;
        bl_log     <= sdram_wire_addr[1:0];
        cl3        <= sdram_wire_addr[4];
      end
      if (cmd_err != 3'd0 && !err_flag) begin
        err_flag <= 1'b1;
        err_code <= cmd_err;
      end
    end
  end

  assign beat_addr = {beat_ba, beat_row, beat_col};
  assign mem_q     = mem[beat_addr];

  // CL=3 enters at stage 0, CL=2 at stage 1; dqm always enters stage 1.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pv  <= '0;
      pd  <= '{default: '0};
      pm1 <= '0;
      pm2 <= '0;
    end else if (cke) begin
      pv    <= {pv[1], pv[0], 1'b0};
      pd[2] <= pd[1];
      pd[1] <= pd[0];
      pm2   <= pm1;
      pm1   <= sdram_wire_dqm;
      if (beat_rd) begin
        if (cl3) begin
          pv[0] <= 1'b1;
          pd[0] <= mem_q;
        end else begin
          pv[1] <= 1'b1;
          pd[1] <= mem_q;
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (beat_wr) begin
      if (!sdram_wire_dqm[0]) mem[beat_addr][7:0]  <= sdram_wire_dq[7:0];
      if (!sdram_wire_dqm[1]) mem[beat_addr][15:8] <= sdram_wire_dq[15:8];
    end
  end

  logic wr_now, drv_lo, drv_hi;

  assign wr_now = beat_wr | (!cke && bstate == B_WRITE);
  assign drv_lo = pv[2] && !wr_now && !pm2[0];
  assign drv_hi = pv[2] && !wr_now && !pm2[1];

  assign sdram_wire_dq[7:0]  = drv_lo ? pd[2][7:0]  : 8'hzz;
  assign sdram_wire_dq[15:8] = drv_hi ? pd[2][15:8] : 8'hzz;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Scoreboard bench for sdram_chip_responder: directed command sequences,
// cycle-stamped expected dq values checked by an independent monitor.
module tb_sdram_chip_responder;
  localparam logic [3:0]  C_NOP = 4'b0111;
  localparam logic [3:0]  C_ACT = 4'b0011;
  localparam logic [3:0]  C_RD  = 4'b0101;
  localparam logic [3:0]  C_WR  = 4'b0100;
  localparam logic [3:0]  C_BST = 4'b0110;
  localparam logic [3:0]  C_LMR = 4'b0000;
  localparam logic [15:0] IDLE  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        cs_n, ras_n, cas_n, we_n;
  logic        cke;
  logic [1:0]  dqm;
  logic        tb_drv;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic        mode_valid, err_flag;
  logic [2:0]  err_code;

  pullup pu_dq (dq);
  assign dq = tb_drv ? tb_dq : 16'hzzzz;

  sdram_chip_responder dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .sdram_wire_addr  (addr),
    .sdram_wire_ba    (ba),
    .sdram_wire_cs_n  (cs_n),
    .sdram_wire_ras_n (ras_n),
    .sdram_wire_cas_n (cas_n),
    .sdram_wire_we_n  (we_n),
    .sdram_wire_cke   (cke),
    .sdram_wire_dqm   (dqm),
    .sdram_wire_dq    (dq),
    .mode_valid       (mode_valid),
    .err_flag         (err_flag),
    .err_code         (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare dq against the scoreboard entry stamped for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].c < cyc) begin
      e = sb.pop_front();
      total++;
      $display("FAIL missed_beat cyc=%0d got none want %h", e.c, e.v);
    end else if (sb.size() != 0 && sb[0].c == cyc) begin
      e = sb.pop_front();
      total++;
      if (dq === e.v) passed++;
      else $display("FAIL beat cyc=%0d got %h want %h", cyc, dq, e.v);
    end else if (!tb_drv && dq !== IDLE) begin
      total++;
      $display("FAIL unexpected_drive cyc=%0d got %h want %h", cyc, dq, IDLE);
    end
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s got %h want %h", name, act, req);
  endtask

  task automatic push(input int c, input logic [15:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [1:0] b,
                         input logic [12:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
  endtask

  task automatic cmd1(input logic [3:0] c, input logic [1:0] b,
                      input logic [12:0] a);
    set_cmd(c, b, a);
    tick();
    set_cmd(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic nops(input int n);
    set_cmd(C_NOP, 2'd0, 13'd0);
    repeat (n) tick();
  endtask

  task automatic wr_burst(input logic [1:0] b, input logic [12:0] a,
                          input logic [15:0] d0, input int n,
                          input logic [1:0] m);
    dqm    = m;
    tb_drv = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == 0) set_cmd(C_WR, b, a);
      else        set_cmd(C_NOP, 2'd0, 13'd0);
      tb_dq = d0 + 16'(k);
      tick();
    end
    set_cmd(C_NOP, 2'd0, 13'd0);
    tb_drv = 1'b0;
    dqm    = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int c;
    rst    = 1'b1;
    cke    = 1'b1;
    dqm    = 2'b00;
    tb_drv = 1'b0;
    tb_dq  = 16'h0000;
    set_cmd(C_NOP, 2'd0, 13'd0);
    repeat (3) tick();
    chk("rst_mode_valid", {15'd0, mode_valid}, 16'd0);
    chk("rst_err_flag", {15'd0, err_flag}, 16'd0);
    chk("rst_err_code", {13'd0, err_code}, 16'd0);
    chk("rst_dq", dq, IDLE);
    rst = 1'b0;
    nops(2);

    // BL=8 CL=2 write then read back
    cmd1(C_LMR, 2'd0, 13'h023);
    cmd1(C_ACT, 2'd1, 13'h003);
    nops(2);
    wr_burst(2'd1, 13'h010, 16'h1000, 8, 2'b00);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h010);
    for (int k = 0; k < 8; k++) push(c + 2 + k, 16'h1000 + 16'(k));
    nops(12);
    chk("t1_mode_valid", {15'd0, mode_valid}, 16'd1);
    chk("t1_err_flag", {15'd0, err_flag}, 16'd0);

    // BL=4 CL=3 wrap order
    cmd1(C_LMR, 2'd0, 13'h032);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h012);
    push(c + 2, IDLE);
    push(c + 3, 16'h1002);
    push(c + 4, 16'h1003);
    push(c + 5, 16'h1000);
    push(c + 6, 16'h1001);
    push(c + 7, IDLE);
    nops(10);

    // byte masks on write and read
    cmd1(C_LMR, 2'd0, 13'h020);
    wr_burst(2'd1, 13'h040, 16'h1234, 1, 2'b00);
    wr_burst(2'd1, 13'h040, 16'hABCD, 1, 2'b10);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h040);
    push(c + 2, 16'h12CD);
    nops(4);
    dqm = 2'b01;
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h040);
    dqm = 2'b00;
    push(c + 2, 16'h12FF);
    nops(4);

    // burst terminate after beat 3
    cmd1(C_LMR, 2'd0, 13'h023);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h010);
    for (int k = 0; k < 4; k++) push(c + 2 + k, 16'h1000 + 16'(k));
    push(c + 6, IDLE);
    push(c + 7, IDLE);
    nops(2);
    cmd1(C_BST, 2'd0, 13'd0);
    nops(8);

    // cke low for 3 cycles mid-read
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h010);
    push(c + 2, 16'h1000);
    for (int k = 3; k <= 6; k++) push(c + k, 16'h1001);
    for (int k = 2; k < 8; k++) push(c + 5 + k, 16'h1000 + 16'(k));
    push(c + 13, IDLE);
    nops(2);
    cke = 1'b0;
    nops(3);
    cke = 1'b1;
    nops(12);
    chk("t6_err_flag", {15'd0, err_flag}, 16'd0);

    // auto-precharge closes bank, then READ to idle bank
    cmd1(C_LMR, 2'd0, 13'h022);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h410);
    for (int k = 0; k < 4; k++) push(c + 2 + k, 16'h1000 + 16'(k));
    push(c + 6, IDLE);
    nops(3);
    cmd1(C_RD, 2'd1, 13'h010);
    nops(4);
    chk("ap_err_flag", {15'd0, err_flag}, 16'd1);
    chk("ap_err_code", {13'd0, err_code}, 16'd2);

    // reset mid-burst releases dq at once
    cmd1(C_ACT, 2'd1, 13'h003);
    nops(2);
    cmd1(C_LMR, 2'd0, 13'h023);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h010);
    push(c + 2, 16'h1000);
    push(c + 3, 16'h1001);
    push(c + 4, IDLE);
    nops(3);
    rst = 1'b1;
    #1;
    chk("rst_mid_dq", dq, IDLE);
    chk("rst_mid_mode_valid", {15'd0, mode_valid}, 16'd0);
    chk("rst_mid_err_flag", {15'd0, err_flag}, 16'd0);
    chk("rst_mid_err_code", {13'd0, err_code}, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    nops(1);

    // memory survives reset
    cmd1(C_LMR, 2'd0, 13'h020);
    cmd1(C_ACT, 2'd1, 13'h003);
    nops(2);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h040);
    push(c + 2, 16'h12CD);
    c = cyc;
    cmd1(C_RD, 2'd1, 13'h017);
    push(c + 2, 16'h1007);
    nops(4);
    chk("reinit_mode_valid", {15'd0, mode_valid}, 16'd1);
    chk("reinit_err_flag", {15'd0, err_flag}, 16'd0);

    // tRCD violation, then a second error leaves the code frozen
    cmd1(C_ACT, 2'd2, 13'h005);
    c = cyc;
    cmd1(C_RD, 2'd2, 13'h000);
    push(c + 2, IDLE);
    nops(3);
    chk("trcd_err_flag", {15'd0, err_flag}, 16'd1);
    chk("trcd_err_code", {13'd0, err_code}, 16'd3);
    cmd1(C_RD, 2'd3, 13'h000);
    nops(4);
    chk("sticky_err_code", {13'd0, err_code}, 16'd3);

    nops(4);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      $display("FAIL leftover cyc=%0d got none want %h", e.c, e.v);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
